// File: rtl/send_data_fsm.sv
// send_data_fsm
//
// Streaming transmitter that sits behind the command decoder. After a single
// en_send pulse the block stays armed until reset. Every accepted 16-bit sum
// sample is sent to the UART TX as one frame: {HEADER, MSB, LSB}, or
// {MSB, LSB} when HEADER_EN=0. Each byte goes out through a tx_start/tx_busy
// handshake. A sample that arrives while a frame is still in flight is dropped,
// and the sticky overrun flag is set.
//
// Parameters
//   HEADER       sync byte sent first in every frame
//   HEADER_EN    1: three-byte frame with header, 0: two-byte frame
//   ACK_TIMEOUT  cycles, counted from the tx_start cycle, to wait for tx_busy
//                to rise before the byte is treated as done (>= 2)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   en_send      1-cycle pulse: start streaming (ignored once streaming)
//   sum_ready    1-cycle pulse: sum_data valid
//   sum_data     16-bit sample to transmit
//   tx_busy      UART TX busy
//   tx_start     1-cycle pulse: load tx_data into the UART TX
//   tx_data      byte to transmit; holds its value between tx_start pulses
//   sending      streaming enabled (sticky until reset)
//   frame_active a frame is in progress
//   overrun      sticky: at least one sample was dropped

module send_data_fsm #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter bit         HEADER_EN   = 1'b1,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_send,
  input  logic        sum_ready,
  input  logic [15:0] sum_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        sending,
  output logic        frame_active,
  output logic        overrun
);

  localparam int         NBYTES   = HEADER_EN ? 3 : 2;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);
  // The counter only has to reach ACK_TIMEOUT-1.
  localparam int         TW       = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT_SAMPLE,
    S_SEND_BYTE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [15:0]   r_shadow,   w_shadow_nxt;
  logic [1:0]    r_idx,      w_idx_nxt;
  logic [TW-1:0] r_tmo,      w_tmo_nxt;
  logic          r_tx_start, w_tx_start_nxt;
  logic [7:0]    r_tx_data,  w_tx_data_nxt;
  logic          r_sending,  w_sending_nxt;
  logic          r_overrun,  w_overrun_nxt;

  logic          w_frame_active;
  logic          w_byte_done;
  logic          w_last_done;
  logic [7:0]    w_byte;

  assign w_frame_active = (r_state == S_SEND_BYTE) ||
                          (r_state == S_WAIT_ACK)  ||
                          (r_state == S_WAIT_DONE);

  // Byte selected by the frame index. The header slot only exists when
  // HEADER_EN is set.
  always_comb begin
    w_byte = r_shadow[7:0];
    if (HEADER_EN) begin
      case (r_idx)
        2'd0:    w_byte = HEADER;
        2'd1:    w_byte = r_shadow[15:8];
        default: w_byte = r_shadow[7:0];
      endcase
    end else begin
      if (r_idx == 2'd0) w_byte = r_shadow[15:8];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_OFF;
      r_shadow   <= 16'h0000;
      r_idx      <= 2'd0;
      r_tmo      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_sending  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shadow   <= w_shadow_nxt;
      r_idx      <= w_idx_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_sending  <= w_sending_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_shadow_nxt   = r_shadow;
    w_idx_nxt      = r_idx;
    w_tmo_nxt      = r_tmo;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_sending_nxt  = r_sending;
    w_overrun_nxt  = r_overrun;
    w_byte_done    = 1'b0;

    case (r_state)
      S_OFF: begin
        // A sample that arrives before streaming is enabled is ignored silently.
        if (en_send) begin
          w_sending_nxt = 1'b1;
          w_state_nxt   = S_WAIT_SAMPLE;
        end
      end

      S_WAIT_SAMPLE: begin
        if (sum_ready) begin
          w_shadow_nxt = sum_data;
          w_idx_nxt    = 2'd0;
          w_state_nxt  = S_SEND_BYTE;
        end
      end

      S_SEND_BYTE: begin
        // Hold off until the UART has drained whatever it is still sending.
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = w_byte;
          w_tmo_nxt      = '0;
          w_state_nxt    = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        // The first WAIT_ACK cycle is the tx_start cycle, so the counter value
        // ACK_TIMEOUT-1 marks the last cycle of the acknowledge window.
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
          w_byte_done = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) w_byte_done = 1'b1;
      end

      default: w_state_nxt = S_OFF;
    endcase

    w_last_done = w_byte_done && (r_idx == LAST_IDX);

    if (w_byte_done) begin
      if (r_idx == LAST_IDX) begin
        // A sample that lands exactly on the completion of the last byte
        // starts the next frame directly, so WAIT_SAMPLE is skipped.
        if (sum_ready) begin
          w_shadow_nxt = sum_data;
          w_idx_nxt    = 2'd0;
          w_state_nxt  = S_SEND_BYTE;
        end else begin
          w_state_nxt  = S_WAIT_SAMPLE;
        end
      end else begin
        w_idx_nxt   = r_idx + 2'd1;
        w_state_nxt = S_SEND_BYTE;
      end
    end

    // Any other sample seen during a frame is dropped. The shadow register
    // is left unchanged so the frame in flight stays consistent.
    if (w_frame_active && sum_ready && !w_last_done) w_overrun_nxt = 1'b1;
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign sending      = r_sending;
  assign frame_active = w_frame_active;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_send_data_fsm.sv
module tb_send_data_fsm;

  localparam int ACK_TO   = 16;
  localparam int BUSY_LEN = 10;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // DUT with header
  logic        en_send, sum_ready, tx_busy, tx_start, sending, frame_active, overrun;
  logic [15:0] sum_data;
  logic [7:0]  tx_data;
  // DUT without header
  logic        en_send_b, sum_ready_b, tx_busy_b, tx_start_b, sending_b, frame_active_b, overrun_b;
  logic [15:0] sum_data_b;
  logic [7:0]  tx_data_b;

  send_data_fsm #(.HEADER(8'hA5), .HEADER_EN(1'b1), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .en_send(en_send), .sum_ready(sum_ready),
    .sum_data(sum_data), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .sending(sending), .frame_active(frame_active), .overrun(overrun));

  send_data_fsm #(.HEADER(8'hA5), .HEADER_EN(1'b0), .ACK_TIMEOUT(ACK_TO)) dut_b (
    .clk(clk), .reset(reset), .en_send(en_send_b), .sum_ready(sum_ready_b),
    .sum_data(sum_data_b), .tx_busy(tx_busy_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .sending(sending_b), .frame_active(frame_active_b), .overrun(overrun_b));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit use_model, ack_en;
  int bcnt, bcnt_b;
  logic [7:0] bytes[$], bytes_b[$];
  int starts[$], starts_b[$];

  typedef struct {
    logic        rst, en, sr;
    logic [15:0] sd;
    logic        busy;
    logic        txs;
    logic [7:0]  txd;
    logic        snd, fa, ovr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic en, input logic sr, input logic [15:0] sd,
                     input logic busy, input logic txs, input logic [7:0] txd,
                     input logic snd, input logic fa, input logic ovr);
    vec_t v;
    v.rst = rst; v.en = en; v.sr = sr; v.sd = sd; v.busy = busy;
    v.txs = txs; v.txd = txd; v.snd = snd; v.fa = fa; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, then act #1 after the edge: record tx_start bytes and
  // run the UART model. The model raises busy in the tx_start cycle and holds
  // it for BUSY_LEN cycles, or never raises it when ack_en=0.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start === 1'b1) begin
      bytes.push_back(tx_data);
      starts.push_back(cyc);
      bcnt = BUSY_LEN;
    end else if (bcnt > 0) bcnt--;
    if (use_model) tx_busy = ack_en && (bcnt > 0);
    if (tx_start_b === 1'b1) begin
      bytes_b.push_back(tx_data_b);
      starts_b.push_back(cyc);
      bcnt_b = BUSY_LEN;
    end else if (bcnt_b > 0) bcnt_b--;
    tx_busy_b = ack_en && (bcnt_b > 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; en_send = 1'b0; sum_ready = 1'b0; en_send_b = 1'b0; sum_ready_b = 1'b0;
    step(); step();
    reset = 1'b0;
    bytes.delete(); bytes_b.delete(); starts.delete(); starts_b.delete();
    bcnt = 0; bcnt_b = 0; tx_busy = 1'b0; tx_busy_b = 1'b0;
  endtask

  task automatic pulse_en();
    en_send = 1'b1; step(); en_send = 1'b0;
  endtask

  task automatic pulse_sr(input logic [15:0] d);
    sum_data = d; sum_ready = 1'b1; step(); sum_ready = 1'b0;
  endtask

  task automatic wait_frame(input int k, input int limit, input string name);
    int n = 0;
    while (!(starts.size() >= k && frame_active == 1'b0) && n < limit) begin
      step(); n++;
    end
    chk(name, 32'(n < limit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int nsr, n;
    bit inj;
    reset = 1'b1; en_send = 1'b0; sum_ready = 1'b0; sum_data = 16'h0; tx_busy = 1'b0;
    en_send_b = 1'b0; sum_ready_b = 1'b0; sum_data_b = 16'h0; tx_busy_b = 1'b0;
    use_model = 1'b0; ack_en = 1'b1; bcnt = 0; bcnt_b = 0;

    // Columns: rst en sr sd busy | tx_start tx_data sending frame_active overrun (after edge)
    add(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b0); // reset
    add(1'b0,1'b0,1'b1,16'hBEEF,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b0); // sample in OFF ignored
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b0);
    add(1'b0,1'b1,1'b1,16'h1111,1'b0, 1'b0,8'h00,1'b1,1'b0,1'b0); // en with sample: sample ignored
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h00,1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,16'h1234,1'b0, 1'b0,8'h00,1'b1,1'b1,1'b0); // cycle N
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,8'hA5,1'b1,1'b1,1'b0); // start at N+2
    add(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,8'hA5,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,8'hA5,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'hA5,1'b1,1'b1,1'b0); // byte 0 done
    add(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,8'hA5,1'b1,1'b1,1'b0); // SEND_BYTE stalls on busy
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,8'h12,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h12,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,8'h12,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h12,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,8'h34,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,8'h34,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h34,1'b1,1'b0,1'b0); // back to WAIT_SAMPLE
    add(1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b0,8'h34,1'b1,1'b0,1'b0); // en while sending ignored
    add(1'b0,1'b0,1'b1,16'h5678,1'b0, 1'b0,8'h34,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,8'hA5,1'b1,1'b1,1'b0);
    add(1'b0,1'b0,1'b1,16'h9999,1'b1, 1'b0,8'hA5,1'b1,1'b1,1'b1); // drop -> overrun
    add(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b0); // reset clears all

    foreach (tbl[i]) begin
      reset = tbl[i].rst; en_send = tbl[i].en; sum_ready = tbl[i].sr;
      sum_data = tbl[i].sd; tx_busy = tbl[i].busy;
      step();
      chk($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(tbl[i].txs));
      chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].txd));
      chk($sformatf("vec%0d_sending", i), 32'(sending), 32'(tbl[i].snd));
      chk($sformatf("vec%0d_frame_active", i), 32'(frame_active), 32'(tbl[i].fa));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
    end
    en_send = 1'b0; sum_ready = 1'b0; tx_busy = 1'b0;
    use_model = 1'b1;

    // Test 1: full frame with the busy model
    do_reset(); ack_en = 1'b1;
    pulse_en(); step();
    nsr = cyc;
    pulse_sr(16'h1234);
    wait_frame(3, 100, "t1_wait");
    chk("t1_count", 32'(starts.size()), 32'd3);
    if (bytes.size() == 3) begin
      chk("t1_b0", 32'(bytes[0]), 32'hA5);
      chk("t1_b1", 32'(bytes[1]), 32'h12);
      chk("t1_b2", 32'(bytes[2]), 32'h34);
      chk("t1_latency", 32'(starts[0] - nsr), 32'd2);
      chk("t1_gap", 32'(starts[1] - starts[0]), 32'(BUSY_LEN + 2));
    end
    chk("t1_sending", 32'(sending), 32'd1);
    chk("t1_overrun", 32'(overrun), 32'd0);

    // Test 3: a second sample mid-frame is dropped, overrun is sticky
    do_reset();
    pulse_en();
    pulse_sr(16'h0001);
    repeat (4) step();
    chk("t3_ovr_before", 32'(overrun), 32'd0);
    pulse_sr(16'h0002);
    chk("t3_ovr_set", 32'(overrun), 32'd1);
    wait_frame(3, 100, "t3_wait");
    if (bytes.size() == 3) begin
      chk("t3_b0", 32'(bytes[0]), 32'hA5);
      chk("t3_b1", 32'(bytes[1]), 32'h00);
      chk("t3_b2", 32'(bytes[2]), 32'h01);
    end
    repeat (40) step();
    chk("t3_no_extra", 32'(starts.size()), 32'd3);
    chk("t3_ovr_sticky", 32'(overrun), 32'd1);

    // Test 4: tx_busy never rises, so every byte times out
    do_reset(); ack_en = 1'b0;
    pulse_en();
    pulse_sr(16'h1234);
    wait_frame(3, 200, "t4_wait");
    repeat (20) step();
    chk("t4_count", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("t4_gap1", 32'(starts[1] - starts[0]), 32'(ACK_TO + 1));
      chk("t4_gap2", 32'(starts[2] - starts[1]), 32'(ACK_TO + 1));
      chk("t4_b2", 32'(bytes[2]), 32'h34);
    end
    chk("t4_idle", 32'(frame_active), 32'd0);
    ack_en = 1'b1;

    // Test 5: reset in the cycle of the 2nd tx_start
    do_reset();
    pulse_en();
    pulse_sr(16'hCAFE);
    n = 0;
    while (starts.size() < 2 && n < 100) begin step(); n++; end
    chk("t5_wait", 32'(n < 100), 32'd1);
    reset = 1'b1;
    step();
    chk("t5_tx_start", 32'(tx_start), 32'd0);
    chk("t5_tx_data", 32'(tx_data), 32'h00);
    chk("t5_sending", 32'(sending), 32'd0);
    chk("t5_frame_active", 32'(frame_active), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    pulse_sr(16'h1111);
    repeat (60) step();
    chk("t5_no_tx", 32'(starts.size()), 32'd2);

    // Test 6: no header; a sample coinciding with last-byte completion chains
    do_reset();
    en_send_b = 1'b1; step(); en_send_b = 1'b0;
    sum_data_b = 16'h1234; sum_ready_b = 1'b1; step(); sum_ready_b = 1'b0;
    n = 0; inj = 1'b0;
    while (!(starts_b.size() >= 4 && frame_active_b == 1'b0) && n < 200) begin
      if (!inj && starts_b.size() == 2 && tx_busy_b == 1'b0) begin
        chk("t6_mid_frame", 32'(frame_active_b), 32'd1);
        sum_data_b = 16'hA55A; sum_ready_b = 1'b1; inj = 1'b1;
      end
      step();
      sum_ready_b = 1'b0;
      n++;
    end
    chk("t6_wait", 32'(n < 200), 32'd1);
    chk("t6_count", 32'(starts_b.size()), 32'd4);
    if (bytes_b.size() == 4) begin
      chk("t6_b0", 32'(bytes_b[0]), 32'h12);
      chk("t6_b1", 32'(bytes_b[1]), 32'h34);
      chk("t6_b2", 32'(bytes_b[2]), 32'hA5);
      chk("t6_b3", 32'(bytes_b[3]), 32'h5A);
      chk("t6_back2back", 32'(starts_b[2] - starts_b[1]), 32'(BUSY_LEN + 2));
    end
    chk("t6_overrun", 32'(overrun_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
